ram8: RTL

RAM8 -- requirements
Module: ram8

---
 rtl/hack_pkg.sv | 17 +
 rtl/dmux8way.sv | 14 +
 rtl/mux8way.sv | 16 +
 rtl/register_w.sv | 20 ++
 rtl/ram8.sv | 57 +++++
 5 files changed

// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared geometry for the eight-word register file
package hack_pkg;

  localparam int DEPTH      = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int WORD_WIDTH = 16;

  // One-hot word select; a clear enable yields an all-zero vector.
  function automatic logic [DEPTH-1:0] word_select(input logic en,
                                                   input logic [ADDR_WIDTH-1:0] addr);
    logic [DEPTH-1:0] sel;
    sel       = '0;
    sel[addr] = en;
    return sel;
  endfunction

endpackage

// File: rtl/dmux8way.sv
// rtl/dmux8way.sv - routes one input bit to exactly one of eight outputs
module dmux8way
  import hack_pkg::*;
(
  input  logic                  in,
  input  logic [ADDR_WIDTH-1:0] sel,
  output logic [DEPTH-1:0]      out
);

  always_comb begin
    out = word_select(in, sel);
  end

endmodule

// File: rtl/mux8way.sv
// rtl/mux8way.sv - eight-way WIDTH-bit read multiplexer
module mux8way
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] d,
  input  logic [ADDR_WIDTH-1:0]       sel,
  output logic [WIDTH-1:0]            out
);

  always_comb begin
    out = d[sel];
  end

endmodule

// File: rtl/register_w.sv
// rtl/register_w.sv - WIDTH-bit load-enabled register with synchronous active-low clear
module register_w #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
    end else if (load) begin
      out <= in;
    end
  end

endmodule

// File: rtl/ram8.sv
// rtl/ram8.sv - eight-word RAM with per-word written flags; RAM8_BYPASS_EN adds write-through forwarding
module ram8
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [WIDTH-1:0]      out,
  output logic [DEPTH-1:0]      valid
);

  logic [DEPTH-1:0]            word_load;
  logic [DEPTH-1:0][WIDTH-1:0] words;
  logic [WIDTH-1:0]            rd_data;

  dmux8way u_decode (
    .in  (load),
    .sel (address),
    .out (word_load)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    register_w #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .load  (word_load[i]),
      .out   (words[i])
    );
  end

  // Flags accumulate until reset; a discarded write during reset never sets one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      valid <= valid | word_load;
    end
  end

  mux8way #(.WIDTH(WIDTH)) u_read (
    .d   (words),
    .sel (address),
    .out (rd_data)
  );

`ifdef RAM8_BYPASS_EN
  assign out = (load && rst_n) ? in : rd_data;
`else
  assign out = rd_data;
`endif

endmodule
